// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the PISO serializer.
// Build option: PISO_PARITY_EN appends an even-parity bit to every frame.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  function automatic int frame_len(input int n);
`ifdef PISO_PARITY_EN
    return n + 1;
`else
    return n;
`endif
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n + 2);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Loadable down-counter tracking the bits left in the current frame.
// Saturates at zero so an idle block never wraps.
module piso_bit_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         last_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (dec_i && cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;
  assign last_o  = (cnt_q == W'(1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out converter with valid/ready intake.
// Build option: PISO_PARITY_EN adds a trailing even-parity bit.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int N         = 4,
  parameter int LSB_FIRST = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] par_in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         ser_out,
  output logic         ser_valid,
  output logic         frame_start,
  output logic         busy
);

  localparam int FL = frame_len(N);
  localparam int CW = cnt_w(N);

  state_e          st_q, st_d;
  logic [FL-1:0]   sh_q, sh_d;
  logic            fs_q, fs_d;
  logic [FL-1:0]   load_word;
  logic [FL-1:0]   shifted;
  logic            accept;
  logic            cnt_load;
  logic            cnt_dec;
  logic            last;
  logic [CW-1:0]   count;

  // Parity rides in the register so it leaves through the same output end.
`ifdef PISO_PARITY_EN
  logic par_bit;
  assign par_bit   = ^par_in;
  assign load_word = (LSB_FIRST != 0) ? {par_bit, par_in}
                                      : {par_in, par_bit};
`else
  assign load_word = par_in;
`endif

  assign shifted = (LSB_FIRST != 0) ? (sh_q >> 1) : (sh_q << 1);

  assign in_ready = rst_n & ((st_q == IDLE) | last);
  assign accept   = in_valid & in_ready;

  always_comb begin
    st_d     = st_q;
    sh_d     = sh_q;
    fs_d     = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    if (accept) begin
      st_d     = SHIFT;
      sh_d     = load_word;
      fs_d     = 1'b1;
      cnt_load = 1'b1;
    end else if (st_q == SHIFT) begin
      sh_d    = shifted;
      cnt_dec = 1'b1;
      if (last) st_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= IDLE;
      sh_q <= '0;
      fs_q <= 1'b0;
    end else begin
      st_q <= st_d;
      sh_q <= sh_d;
      fs_q <= fs_d;
    end
  end

  piso_bit_counter #(.W(CW)) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (cnt_load),
    .load_val_i(CW'(FL)),
    .dec_i     (cnt_dec),
    .count_o   (count),
    .last_o    (last)
  );

  assign busy        = (st_q == SHIFT);
  assign ser_valid   = busy;
  assign frame_start = fs_q;
  assign ser_out     = busy & ((LSB_FIRST != 0) ? sh_q[0] : sh_q[FL-1]);

endmodule
